// File: rtl/dma_blockmove.sv
// Block-move engine on one port of the dual-port work RAM: copies RAM to RAM
// (read, then write, per byte) or fills a range with a constant (one write per byte).
module dma_blockmove #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    io_addr,
    input  logic          io_wr,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic [AW-1:0] mem_ad,
    output logic [DW-1:0] mem_din,
    output logic          mem_ce,
    output logic          mem_we,
    output logic          mem_oce,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done_pulse
);

    // state  | meaning
    // S_IDLE | no transfer, RAM port quiet, registers writable
    // S_RD   | copy only: read SRC, data returns next cycle
    // S_WR   | write DST with mem_dout (copy) or FILL (fill), then advance
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [DW-1:0] fill_q, fill_d;
    logic          mode_q, mode_d, done_q, done_d, pulse_q, pulse_d;
    logic [AW-1:0] len_dec;
    logic          ctrl_wr, start, abort, last;

    assign ctrl_wr = io_wr && (io_addr == 3'd7);
    // ABORT beats START when both arrive in the same write
    assign abort   = ctrl_wr && io_wdata[2];
    assign start   = ctrl_wr && io_wdata[0] && !io_wdata[2];
    assign len_dec = len_q - AW'(1);
    assign last    = (len_dec == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && (len_q != '0)) state_d = io_wdata[1] ? S_WR : S_RD;
            S_RD:   state_d = abort ? S_IDLE : S_WR;
            S_WR: begin
                if (abort || last) state_d = S_IDLE;
                else               state_d = mode_q ? S_WR : S_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ce  = 1'b0;
        mem_we  = 1'b0;
        mem_ad  = '0;
        mem_din = '0;
        case (state_q)
            S_RD: begin
                mem_ce = 1'b1;
                mem_ad = src_q;
            end
            S_WR: begin
                mem_ce  = 1'b1;
                mem_we  = 1'b1;
                mem_ad  = dst_q;
                mem_din = mode_q ? fill_q : mem_dout;
            end
            default: ;
        endcase
    end

    assign mem_oce    = 1'b1;
    assign busy       = (state_q != S_IDLE);
    assign done_pulse = pulse_q;

    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        done_d  = done_q;
        pulse_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (io_wr) begin
                case (io_addr)
                    3'd0: src_d[DW-1:0]  = io_wdata;
                    3'd1: src_d[AW-1:DW] = io_wdata[AW-DW-1:0];
                    3'd2: dst_d[DW-1:0]  = io_wdata;
                    3'd3: dst_d[AW-1:DW] = io_wdata[AW-DW-1:0];
                    3'd4: len_d[DW-1:0]  = io_wdata;
                    3'd5: len_d[AW-1:DW] = io_wdata[AW-DW-1:0];
                    3'd6: fill_d         = io_wdata;
                    default: begin
                        if (start) begin
                            mode_d  = io_wdata[1];
                            done_d  = (len_q == '0);
                            pulse_d = (len_q == '0);
                        end
                    end
                endcase
            end
        end else if (state_q == S_WR) begin
            // the write in flight always completes, so progress advances even on abort
            dst_d = dst_q + AW'(1);
            if (!mode_q) src_d = src_q + AW'(1);
            len_d = len_dec;
            if (last && !abort) begin
                done_d  = 1'b1;
                pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            3'd0:    io_rdata = src_q[DW-1:0];
            3'd1:    io_rdata = DW'(src_q >> DW);
            3'd2:    io_rdata = dst_q[DW-1:0];
            3'd3:    io_rdata = DW'(dst_q >> DW);
            3'd4:    io_rdata = len_q[DW-1:0];
            3'd5:    io_rdata = DW'(len_q >> DW);
            3'd6:    io_rdata = fill_q;
            default: io_rdata = {{(DW-3){1'b0}}, mode_q, done_q, busy};
        endcase
    end

endmodule

// File: tb/tb_dma_blockmove.sv
// Bench for dma_blockmove: a RAM model on the engine's port, a reference model of
// the block move feeding an expected-write queue, and a monitor checking each RAM write.
module tb_dma_blockmove;
    localparam int AW   = 14;
    localparam int MASK = (1 << AW) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  io_addr = '0;
    logic        io_wr = 1'b0;
    logic [7:0]  io_wdata = '0;
    logic [7:0]  io_rdata;
    logic [13:0] mem_ad;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = '0;
    logic        mem_ce, mem_we, mem_oce, busy, done_pulse;

    logic [7:0]  ram     [0:16383];
    logic [7:0]  ref_mem [0:16383];
    logic [21:0] exp_q[$];
    logic [21:0] e;

    int compared = 0, mismatched = 0;
    int busy_cnt = 0, pulse_cnt = 0, ce_cnt = 0;

    dma_blockmove #(.AW(14), .DW(8)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_wr(io_wr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .mem_ad(mem_ad), .mem_din(mem_din), .mem_ce(mem_ce),
        .mem_we(mem_we), .mem_oce(mem_oce), .mem_dout(mem_dout), .busy(busy),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // registered-read RAM port
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_ad] <= mem_din;
            else        mem_dout    <= ram[mem_ad];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (busy)       busy_cnt++;
            if (done_pulse) pulse_cnt++;
            if (mem_ce)     ce_cnt++;
            if (mem_ce && mem_we) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", mem_ad, mem_din);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {mem_ad, mem_din}) begin
                        mismatched++;
                        $display("FAIL ram_write: got addr %h data %h, expected addr %h data %h",
                                 mem_ad, mem_din, e[21:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        io_wr = 1'b1; io_addr = a[2:0]; io_wdata = d[7:0];
        @(posedge clk); #1;
        io_wr = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        io_addr = a[2:0];
        #1;
        v = int'(io_rdata);
    endtask

    task automatic rd14(input int lo, output int v);
        int a, b;
        rd(lo, a);
        rd(lo + 1, b);
        v = b * 256 + a;
    endtask

    task automatic prog(input int src, input int dst, input int len, input int fill);
        wr(0, src & 255); wr(1, (src >> 8) & 255);
        wr(2, dst & 255); wr(3, (dst >> 8) & 255);
        wr(4, len & 255); wr(5, (len >> 8) & 255);
        wr(6, fill);
    endtask

    // reference: ascending byte-serial move over a modulo-2^AW address space
    task automatic model_xfer(input int mode, input int src, input int dst, input int fill, input int n);
        int a;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            a = (dst + i) & MASK;
            d = mode ? fill[7:0] : ref_mem[(src + i) & MASK];
            ref_mem[a] = d;
            exp_q.push_back({a[13:0], d});
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        chk({name, "_timeout"}, int'(busy), 0);
    endtask

    task automatic run_xfer(input string name, input int mode, input int src, input int dst,
                            input int len, input int fill);
        int b0, p0, c0, v;
        prog(src, dst, len, fill);
        model_xfer(mode, src, dst, fill, len);
        b0 = busy_cnt; p0 = pulse_cnt; c0 = ce_cnt;
        wr(7, mode ? 3 : 1);
        wait_idle(name);
        repeat (2) begin @(posedge clk); #1; end
        chk({name, "_busy_cycles"}, busy_cnt - b0, mode ? len : 2 * len);
        chk({name, "_ce_cycles"}, ce_cnt - c0, mode ? len : 2 * len);
        chk({name, "_done_pulses"}, pulse_cnt - p0, 1);
        rd14(0, v); chk({name, "_src_end"}, v, mode ? src : ((src + len) & MASK));
        rd14(2, v); chk({name, "_dst_end"}, v, (dst + len) & MASK);
        rd14(4, v); chk({name, "_len_end"}, v, 0);
        rd(7, v);   chk({name, "_ctrl"}, v, mode ? 6 : 2);
    endtask

    initial begin
        int v, w, b0, p0, c0, src, dst, n, md, bad;
        logic aborted;
        for (int i = 0; i < 16384; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0010] = 8'h7E;
        ref_mem[16'h0100] = 8'h11; ref_mem[16'h0101] = 8'h22; ref_mem[16'h0102] = 8'h33;
        ref_mem[16'h0010] = 8'h7E;

        #2;
        chk("rst_outputs", int'({busy, done_pulse, mem_ce, mem_we, mem_ad, mem_din}), 0);
        for (int a = 0; a < 8; a++) begin rd(a, v); chk("rst_reg", v, 0); end
        #9 reset = 1'b0;

        wr(1, 8'hFF); rd(1, v); chk("src_hi_width", v, 8'h3F);
        rd(7, v); chk("ctrl_idle", v, 0);

        run_xfer("copy3", 0, 16'h0100, 16'h2000, 3, 0);
        run_xfer("fill_wrap", 1, 16'h0055, 16'h3FFE, 4, 8'hA5);
        run_xfer("zero_len", 0, 16'h0200, 16'h0300, 0, 0);
        run_xfer("overlap", 0, 16'h0010, 16'h0011, 4, 0);
        for (int i = 16'h11; i <= 16'h14; i++) chk("overlap_ram", int'(ram[i]), 8'h7E);

        // START+ABORT together while idle starts nothing
        prog(16'h0500, 16'h0600, 5, 0);
        b0 = busy_cnt; c0 = ce_cnt; p0 = pulse_cnt;
        wr(7, 5);
        repeat (4) begin @(posedge clk); #1; end
        chk("start_abort_busy", busy_cnt - b0, 0);
        chk("start_abort_ce", ce_cnt - c0, 0);
        chk("start_abort_pulse", pulse_cnt - p0, 0);
        rd(7, v); chk("start_abort_ctrl", v, 2);

        // 100-byte copy aborted right after the 10th write
        prog(16'h0400, 16'h1000, 100, 0);
        model_xfer(0, 16'h0400, 16'h1000, 0, 10);
        p0 = pulse_cnt;
        wr(7, 1);
        w = 0; aborted = 1'b0;
        for (int cyc = 0; cyc < 1000 && !aborted; cyc++) begin
            @(posedge clk); #1;
            if (mem_we) w++;
            if (cyc == 0) begin io_addr = 3'd7; #1; chk("ctrl_busy", int'(io_rdata), 1); end
            if (cyc == 2) begin io_wr = 1'b1; io_addr = 3'd4; io_wdata = 8'h55; end
            if (cyc == 3) begin io_addr = 3'd7; io_wdata = 8'h03; end
            if (cyc == 4) io_wr = 1'b0;
            if (w == 10) begin io_wr = 1'b1; io_addr = 3'd7; io_wdata = 8'h04; aborted = 1'b1; end
        end
        chk("abort_reached", int'(aborted), 1);
        @(posedge clk); #1;
        io_wr = 1'b0;
        chk("abort_busy_drop", int'(busy), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_pulse", pulse_cnt - p0, 0);
        rd14(4, v); chk("abort_len", v, 90);
        rd14(2, v); chk("abort_dst", v, 16'h100A);
        rd14(0, v); chk("abort_src", v, 16'h040A);
        rd(7, v);   chk("abort_ctrl", v, 0);

        for (int t = 0; t < 8; t++) begin
            md  = int'($urandom_range(0, 1));
            src = int'($urandom_range(0, MASK));
            dst = (t % 3 == 0) ? ((src + int'($urandom_range(1, 3))) & MASK) : int'($urandom_range(0, MASK));
            n   = int'($urandom_range(1, 40));
            run_xfer("random", md, src, dst, n, int'($urandom_range(0, 255)));
        end

        // reset in the cycle of the 3rd write of a copy: only two writes land
        prog(16'h0800, 16'h0900, 20, 0);
        model_xfer(0, 16'h0800, 16'h0900, 0, 2);
        wr(7, 1);
        w = 0;
        for (int cyc = 0; cyc < 200 && w < 3; cyc++) begin
            @(posedge clk); #1;
            if (mem_we) w++;
        end
        chk("reset_reached", w, 3);
        #3 reset = 1'b1;
        #1;
        chk("reset_async_outputs", int'({busy, done_pulse, mem_ce, mem_we, mem_ad, mem_din}), 0);
        #7 reset = 1'b0;
        for (int a = 0; a < 8; a++) begin rd(a, v); chk("reset_reg", v, 0); end
        repeat (20) begin @(posedge clk); #1; end

        chk("queue_drained", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 16384; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dma_blockmove.md
Name: dma_blockmove

Overview:
- Block-transfer engine that owns one port of the 16K x 8 dual-port work RAM. The Z80 keeps the other port.
- The CPU programs it through eight 8-bit I/O registers. It then copies a block (RAM to RAM) or fills a block with a constant, with no CPU involvement.
- It drives the RAM port's address, data, enable and write-enable signals directly. It consumes the port's registered read data, which has a 1-cycle latency.

Parameters:
- AW, 14, RAM address width; addresses wrap modulo 2^AW.
- DW, 8, RAM data width and I/O register width.

Ports:
- clk  in  1  single clock for the engine and the RAM port.
- reset  in  1  asynchronous, active-high reset.
- io_addr  in  3  register select.
- io_wr  in  1  register write strobe, sampled on rising clk.
- io_wdata  in  DW  register write data.
- io_rdata  out  DW  combinational readback of the register selected by io_addr.
- mem_ad  out  AW  RAM port address.
- mem_din  out  DW  RAM port write data.
- mem_ce  out  1  RAM port enable.
- mem_we  out  1  RAM port write enable; only meaningful with mem_ce.
- mem_oce  out  1  output-register enable; tied to 1.
- mem_dout  in  DW  RAM port registered read data (valid the cycle after a read).
- busy  out  1  transfer in progress.
- done_pulse  out  1  one-cycle pulse when a transfer completes normally.

Behaviour:
- Register map (io_addr):
  - 0: SRC[7:0]
  - 1: SRC[AW-1:8] (upper bits read 0)
  - 2: DST[7:0]
  - 3: DST[AW-1:8]
  - 4: LEN[7:0]
  - 5: LEN[AW-1:8]
  - 6: FILL value
  - 7: CTRL
- CTRL write bits: bit0 START, bit1 MODE (0 = copy, 1 = fill), bit2 ABORT.
- CTRL read bits: bit0 busy, bit1 DONE (sticky), bit2 MODE; other bits 0.
- Reset (async): clears all registers, state = IDLE, DONE = 0. Outputs reset to: busy = 0, done_pulse = 0, mem_ce = 0, mem_we = 0, mem_ad = 0, mem_din = 0.
- Register writes to 0-6 while busy are ignored.
- While busy, a CTRL write honours only ABORT; START is ignored.
- States: IDLE, RD, WR.
- START in IDLE:
  - latches MODE and clears DONE;
  - if LEN == 0: stays IDLE, sets DONE, pulses done_pulse next cycle, no memory access;
  - otherwise enters RD (copy) or WR (fill) on the next cycle; busy = 1 from that cycle.
- RD (copy only): mem_ce = 1, mem_we = 0, mem_ad = SRC. Next state is WR.
- WR:
  - mem_ce = 1, mem_we = 1, mem_ad = DST;
  - mem_din = mem_dout in copy mode, FILL in fill mode.
- At the end of each WR cycle:
  - DST += 1 (wraps 2^AW-1 -> 0);
  - in copy mode, SRC += 1 (wraps the same way);
  - LEN -= 1;
  - if the new LEN == 0: go to IDLE, set DONE, assert done_pulse for the following cycle;
  - else: next state is RD (copy) or WR (fill).
- Throughput: copy takes 2 cycles per byte, fill 1 cycle per byte. A copy of N bytes keeps busy high for exactly 2N cycles, a fill for N cycles.
- SRC, DST and LEN update live. Readback shows progress; after completion SRC/DST point one past the block and LEN = 0.
- Overlap: the copy is strictly ascending and byte-serial. When DST > SRC and the ranges overlap, the source bytes replicate; this is defined behaviour, not an error.
- ABORT while busy: the next state is IDLE and mem_ce = 0 from the next cycle. Any write already issued in the current cycle completes. DONE is not set, done_pulse does not fire, and the registers hold their partial-progress values.
- ABORT while IDLE has no effect.
- START and ABORT in the same write while IDLE: ABORT wins and no transfer starts.
- mem_ce = 0 in IDLE. The RAM port performs no accesses other than those listed above.

Test Plan:
- Copy: RAM[0x0100..0x0102] = 11,22,33; SRC = 0x0100, DST = 0x2000, LEN = 3; CTRL = 0x01 -> busy for 6 cycles; RAM[0x2000..0x2002] = 11,22,33; done_pulse once; CTRL reads 0x02; SRC = 0x0103, LEN = 0.
- Fill: FILL = 0xA5, DST = 0x3FFE, LEN = 4, CTRL = 0x03 -> writes 0x3FFE, 0x3FFF, 0x0000, 0x0001 with A5 in 4 consecutive cycles; DST ends at 0x0002.
- Zero length: LEN = 0, START -> no mem_ce assertion, busy never high, done_pulse one cycle later, DONE = 1.
- Overlap: RAM[0x10] = 7E; SRC = 0x10, DST = 0x11, LEN = 4 -> RAM[0x11..0x14] all 7E.
- Abort: a 100-byte copy aborted after 10 bytes -> busy drops the next cycle; LEN = 90, DST = base + 10; no done_pulse; DONE = 0. Register writes during busy are ignored; a START write during busy does not restart.
- Reset mid-copy -> all outputs 0 immediately (asynchronous); registers cleared; no further RAM writes.
